trace_sink: RTL and testbench
=============================

Name: trace_sink

Overview:
- Consumer end of the trace unit's output interface: captures each trace record when `trace_ready` pulses and buffers it in a FIFO.
- Serializes each buffered record into 32-bit words on a valid/ready stream, for a debug port or trace RAM writer.
- Sits beside `trace_unit` in the system top and testbench.
- The trace unit cannot be back-pressured, so overflow is handled by dropping and counting records.

Parameters:
- DATA_WIDTH, 32, output word width.
- TRACE_WORDS, 3, words per trace record; record width = TRACE_WORDS*DATA_WIDTH.
- FIFO_DEPTH, 8, records buffered; power of two, >=2.
- DROP_CNT_W, 16, width of the dropped-record counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- trace_valid_i  in  1  record strobe; driven by the trace unit's `trace_ready`.
- trace_data_i  in  TRACE_WORDS*DATA_WIDTH  flattened `trace_output` record; word 0 = bits [31:0].
- clear_i  in  1  synchronous clear of `overflow_o` and `drop_count_o`.
- out_valid_o  out  1  output word valid.
- out_ready_i  in  1  downstream accepts word.
- out_data_o  out  DATA_WIDTH  output word.
- out_last_o  out  1  final word of the current record.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  records held, excluding the record being serialized.
- overflow_o  out  1  sticky: at least one record dropped.
- drop_count_o  out  DROP_CNT_W  dropped records, saturating.

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs 0, FIFO emptied, FSM to IDLE. Any partially sent record is discarded; `out_valid_o` falls immediately.
- Push: `trace_valid_i` high is accepted if `fifo_level_o < FIFO_DEPTH`, or if a FIFO pop occurs in the same cycle (full + simultaneous pop = accepted).
- Drop: otherwise the record is dropped:
  - `drop_count_o` += 1, saturating at all-ones;
  - `overflow_o` set.
- `clear_i` zeroes both on the next edge. If a drop coincides with `clear_i`, result is `drop_count_o = 1`, `overflow_o = 1` (event wins).
- Serializer FSM: IDLE -> SEND -> IDLE.
  - IDLE: if FIFO non-empty, pop the head into the holding register, idx = 0, go to SEND.
  - SEND: `out_valid_o = 1`, `out_data_o` = holding word[idx], `out_last_o = (idx == last)`.
  - On `out_valid_o && out_ready_i`: if not last, idx += 1. If last, pop next record directly if FIFO non-empty (stay in SEND, idx = 0, no bubble); else go to IDLE.
- Latency: a push at edge N into an empty sink with FSM in IDLE gives `out_valid_o` high after edge N+1. A push while IDLE is never bypassed combinationally.
- Output stability: `out_data_o` and `out_last_o` stay stable while `out_valid_o && !out_ready_i`. `out_valid_o` never drops without a handshake, except on reset.
- Ordering: records are emitted in arrival order; words within a record go word 0 first.
- Capacity: total records held is FIFO_DEPTH + 1 (holding register).
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH. Full/empty use the extra MSB on the pointers.

Optional Feature:
- Macro: TRACE_SINK_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running cycle counter resets to 0, increments every cycle, and wraps.
  - Its value at push time is stored with the record (FIFO entry widens by 32).
  - The value is emitted as word 0 of each record, before the trace words; a record is TRACE_WORDS+1 words.
  - Dropped records are not stamped.
- Undefined: no counter, entry width = record width, TRACE_WORDS words per record.

Decomposition:
- `ryuki_datatypes` gains:
  - `TRACE_WORDS` and `TRACE_SINK_WORD_W` constants;
  - `trace_sink_state_t` enum {IDLE, SEND};
  - `trace_sink_entry_t` packed struct (optional timestamp + record).
- One sub-module, `trace_sink_fifo`: a generic synchronous FIFO with WIDTH and DEPTH parameters and push/pop/full/empty/level ports. It is instantiated once; the serializer FSM and counters live in `trace_sink`.

Test Plan:
- Single record: pulse `trace_valid_i` with words 0x11111111, 0x22222222, 0x33333333, `out_ready_i` = 1 -> three words in that order on consecutive cycles from edge N+1; `out_last_o` only on 0x33333333.
- Back-pressure: `out_ready_i` = 0 for 5 cycles mid-record -> `out_data_o`/`out_last_o` held constant, no word skipped or repeated.
- Overflow: `out_ready_i` = 0, push 12 records -> 9 held (8 FIFO + 1 holding), `fifo_level_o` = 8, `drop_count_o` = 3, `overflow_o` = 1. With `clear_i` and a drop in the same cycle -> count 1.
- Full + simultaneous pop: FIFO full, push coincides with the last-word handshake -> record accepted, `drop_count_o` unchanged.
- Reset mid-record: assert `rst_i` after word 1 of 3 -> `out_valid_o` = 0 immediately. After release, a new record emits from word 0.
- TRACE_SINK_TIMESTAMP_EN: push at cycle 40 after reset -> first word 40, then 3 trace words, `out_last_o` on word 4.

Source files
------------

// File: rtl/trace_sink_pkg.sv
// Shared types and constants for the trace sink. The optional TRACE_SINK_TIMESTAMP_EN
// build adds a 32-bit arrival stamp to every buffered record.
package trace_sink_pkg;

    localparam int TRACE_WORDS       = 3;
    localparam int TRACE_SINK_WORD_W = 32;
    localparam int TRACE_SINK_TS_W   = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } trace_sink_state_t;

    // Word 0 of an entry sits in the LSBs, so the stamp (when present) is last in the struct
    typedef struct packed {
        logic [TRACE_WORDS*TRACE_SINK_WORD_W-1:0] record;
`ifdef TRACE_SINK_TIMESTAMP_EN
        logic [TRACE_SINK_TS_W-1:0]               stamp;
`endif
    } trace_sink_entry_t;

endpackage

// File: rtl/trace_sink_fifo.sv
// Generic synchronous FIFO; pointers carry one extra MSB so full and empty are distinct.
module trace_sink_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data_i;
    end

    assign pop_data_o = mem[rd_ptr[AW-1:0]];
    assign empty_o    = (wr_ptr == rd_ptr);
    assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level_o    = wr_ptr - rd_ptr;

endmodule

// File: rtl/trace_sink.sv
// Buffers trace records and serializes them as DATA_WIDTH words on a valid/ready stream.
// Define TRACE_SINK_TIMESTAMP_EN to prefix each record with its 32-bit arrival cycle.
module trace_sink
    import trace_sink_pkg::trace_sink_state_t, trace_sink_pkg::IDLE, trace_sink_pkg::SEND,
           trace_sink_pkg::TRACE_SINK_TS_W;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TRACE_WORDS = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              trace_valid_i,
    input  logic [TRACE_WORDS*DATA_WIDTH-1:0] trace_data_i,
    input  logic                              clear_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [DATA_WIDTH-1:0]             out_data_o,
    output logic                              out_last_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
    output logic                              overflow_o,
    output logic [DROP_CNT_W-1:0]             drop_count_o
);

`ifdef TRACE_SINK_TIMESTAMP_EN
    localparam int REC_WORDS = TRACE_WORDS + 1;
`else
    localparam int REC_WORDS = TRACE_WORDS;
`endif
    localparam int ENTRY_W = REC_WORDS * DATA_WIDTH;
    localparam int IDX_W   = (REC_WORDS > 1) ? $clog2(REC_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_WORDS - 1);

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    trace_sink_state_t                   state;
    logic [REC_WORDS-1:0][DATA_WIDTH-1:0] hold;
    logic [IDX_W-1:0]                    idx;
    logic [ENTRY_W-1:0]                  push_data;
    logic [ENTRY_W-1:0]                  pop_data;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                at_last;
    logic                                handshake;
    logic                                pop;
    logic                                push;
    logic                                drop;

`ifdef TRACE_SINK_TIMESTAMP_EN
    logic [TRACE_SINK_TS_W-1:0] ts_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end

    assign push_data = {trace_data_i, DATA_WIDTH'(ts_q)};
`else
    assign push_data = trace_data_i;
`endif

    // A full FIFO still accepts when the serializer drains its head in the same cycle
    assign at_last   = (idx == LAST_IDX);
    assign handshake = out_valid_o && out_ready_i;
    assign pop       = !fifo_empty && ((state == IDLE) || (handshake && at_last));
    assign push      = trace_valid_i && (!fifo_full || pop);
    assign drop      = trace_valid_i && !push;

    trace_sink_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (pop_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            idx         <= '0;
            hold        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold        <= pop_data;
                        idx         <= '0;
                        state       <= SEND;
                        out_valid_o <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        if (!at_last) begin
                            idx <= idx + 1'b1;
                        end else if (pop) begin
                            hold <= pop_data;
                            idx  <= '0;
                        end else begin
                            state       <= IDLE;
                            out_valid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign out_data_o = hold[idx];
    assign out_last_o = out_valid_o && at_last;

    // A drop in the same cycle as a clear leaves a count of one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (drop) begin
            drop_count_o <= clear_i ? DROP_CNT_W'(1) : sat_inc(drop_count_o);
            overflow_o   <= 1'b1;
        end else if (clear_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trace_sink.sv
// Randomized bench for trace_sink against a queue-based record model, plus directed cases.
module tb_trace_sink;

    localparam int DW    = 32;
    localparam int TW    = 3;
    localparam int DEPTH = 8;
    localparam int CW    = 16;
`ifdef TRACE_SINK_TIMESTAMP_EN
    localparam int NW  = TW + 1;
    localparam int OFS = 1;
`else
    localparam int NW  = TW;
    localparam int OFS = 0;
`endif
    localparam int EW = NW * DW;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           trace_valid_i = 1'b0;
    logic [TW*DW-1:0] trace_data_i = '0;
    logic           clear_i = 1'b0;
    logic           out_ready_i = 1'b0;
    logic           out_valid_o;
    logic [DW-1:0]  out_data_o;
    logic           out_last_o;
    logic [3:0]     fifo_level_o;
    logic           overflow_o;
    logic [CW-1:0]  drop_count_o;

    trace_sink #(
        .DATA_WIDTH  (DW),
        .TRACE_WORDS (TW),
        .FIFO_DEPTH  (DEPTH),
        .DROP_CNT_W  (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .trace_valid_i (trace_valid_i),
        .trace_data_i  (trace_data_i),
        .clear_i       (clear_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .fifo_level_o  (fifo_level_o),
        .overflow_o    (overflow_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: records waiting in the buffer, plus the record being sent
    logic [EW-1:0] m_fifo[$];
    logic [EW-1:0] m_cur   = '0;
    bit            m_busy  = 1'b0;
    int            m_idx   = 0;
    int            m_drops = 0;
    bit            m_ovf   = 1'b0;
    logic [31:0]   m_ts    = '0;
    bit            stall   = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    function automatic logic [DW-1:0] word_of(input logic [EW-1:0] e, input int i);
        return e[i*DW +: DW];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst_i) begin
                m_fifo.delete();
                m_busy  = 1'b0;
                m_idx   = 0;
                m_drops = 0;
                m_ovf   = 1'b0;
                m_ts    = '0;
                stall   = 1'b0;
            end else begin : model_step
                bit hs;
                bit lastw;
                bit pop;
                bit acc;
                logic [EW-1:0] ent;
                stall = m_busy && !out_ready_i;
                hs    = m_busy && out_ready_i;
                lastw = (m_idx == NW - 1);
                pop   = (m_fifo.size() > 0) && (!m_busy || (hs && lastw));
                acc   = trace_valid_i && ((m_fifo.size() < DEPTH) || pop);
`ifdef TRACE_SINK_TIMESTAMP_EN
                ent = {trace_data_i, m_ts};
`else
                ent = trace_data_i;
`endif
                m_ts++;
                if (hs && !lastw) begin
                    m_idx++;
                end else if (pop) begin
                    m_cur  = m_fifo.pop_front();
                    m_idx  = 0;
                    m_busy = 1'b1;
                end else if (hs) begin
                    m_busy = 1'b0;
                end
                if (acc) m_fifo.push_back(ent);
                if (trace_valid_i && !acc) begin
                    m_ovf   = 1'b1;
                    m_drops = clear_i ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
                end else if (clear_i) begin
                    m_ovf   = 1'b0;
                    m_drops = 0;
                end
            end
            @(negedge clk);
            check("valid", 64'(out_valid_o), 64'(m_busy));
            if (m_busy) begin
                check("data", 64'(out_data_o), 64'(word_of(m_cur, m_idx)));
                check("last", 64'(out_last_o), 64'(m_idx == NW - 1));
            end
            if (stall) begin
                check("stall_data", 64'(out_data_o), 64'(prev_data));
                check("stall_last", 64'(out_last_o), 64'(prev_last));
            end
            check("level", 64'(fifo_level_o), 64'(m_fifo.size()));
            check("drops", 64'(drop_count_o), 64'(m_drops));
            check("overflow", 64'(overflow_o), 64'(m_ovf));
            prev_data = out_data_o;
            prev_last = out_last_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [TW*DW-1:0] d);
        trace_valid_i = 1'b1;
        trace_data_i  = d;
        step();
        trace_valid_i = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid_o && n < 50) begin
            step();
            n++;
        end
        n_chk++;
        if (!out_valid_o) begin
            n_fail++;
            $display("FAIL %s: out_valid_o low after %0d cycles, required high", name, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        out_ready_i = 1'b1;
        while ((out_valid_o || fifo_level_o != 0) && n < 200) begin
            step();
            n++;
        end
        n_chk++;
        if (out_valid_o || fifo_level_o != 0) begin
            n_fail++;
            $display("FAIL drain: level %0d valid %0b after %0d cycles, required empty", fifo_level_o, out_valid_o, n);
        end
    endtask

    logic [DW-1:0] lit [TW];
    logic [TW*DW-1:0] rec;
    logic [DW-1:0] exp_first;

    initial begin
        lit[0] = 32'h11111111;
        lit[1] = 32'h22222222;
        lit[2] = 32'h33333333;

        step();
        step();
        check("rst_valid", 64'(out_valid_o), 64'(0));
        check("rst_data", 64'(out_data_o), 64'(0));
        check("rst_last", 64'(out_last_o), 64'(0));
        check("rst_level", 64'(fifo_level_o), 64'(0));
        check("rst_drops", 64'(drop_count_o), 64'(0));
        check("rst_ovf", 64'(overflow_o), 64'(0));
        rst_i = 1'b0;
        step();

        // Single record, word 0 first, last flag only on the final word
        out_ready_i = 1'b1;
        push({lit[2], lit[1], lit[0]});
        check("no_bypass", 64'(out_valid_o), 64'(0));
        step();
        for (int i = 0; i < NW; i++) begin
            check("single_valid", 64'(out_valid_o), 64'(1));
            if (i >= OFS) check("single_data", 64'(out_data_o), 64'(lit[i-OFS]));
            check("single_last", 64'(out_last_o), 64'(i == NW - 1));
            step();
        end
        check("single_done", 64'(out_valid_o), 64'(0));

        // Back-pressure for five cycles on the second word
        rec = {32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
        push(rec);
        step();
        step();
        out_ready_i = 1'b0;
        repeat (5) step();
        check("bp_valid", 64'(out_valid_o), 64'(1));
        check("bp_data", 64'(out_data_o), 64'(word_of({rec, 32'h0}, 1 + 1 - OFS)));
        drain();

        // Overflow: 12 pushes with no drain -> 1 held + 8 buffered + 3 dropped
        out_ready_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            trace_valid_i = 1'b1;
            trace_data_i  = {$urandom, $urandom, $urandom};
            step();
        end
        trace_valid_i = 1'b0;
        check("ovf_level", 64'(fifo_level_o), 64'(8));
        check("ovf_drops", 64'(drop_count_o), 64'(3));
        check("ovf_flag", 64'(overflow_o), 64'(1));
        check("ovf_holding", 64'(out_valid_o), 64'(1));

        // Push into a full FIFO on the last-word handshake is accepted
        out_ready_i = 1'b1;
        for (int n = 0; n < 10 && !out_last_o; n++) step();
        check("fullpop_at_last", 64'(out_last_o), 64'(1));
        push({$urandom, $urandom, $urandom});
        out_ready_i = 1'b0;
        check("fullpop_drops", 64'(drop_count_o), 64'(3));
        check("fullpop_level", 64'(fifo_level_o), 64'(8));

        // Drop coinciding with clear leaves count 1
        trace_valid_i = 1'b1;
        clear_i       = 1'b1;
        step();
        trace_valid_i = 1'b0;
        clear_i       = 1'b0;
        check("clrdrop_cnt", 64'(drop_count_o), 64'(1));
        check("clrdrop_ovf", 64'(overflow_o), 64'(1));
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check("clr_cnt", 64'(drop_count_o), 64'(0));
        check("clr_ovf", 64'(overflow_o), 64'(0));
        drain();

        // Reset while the second word is on the bus
        rec = {32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
        push(rec);
        wait_valid("mid_rst_start");
        step();
        check("mid_word1", 64'(out_data_o), 64'(word_of({rec, 32'h0}, 1 + 1 - OFS)));
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid_o), 64'(0));
        check("rst_async_level", 64'(fifo_level_o), 64'(0));
        step();
        rst_i = 1'b0;
        step();
        rec = {32'h00000F03, 32'h00000F02, 32'h00000F01};
`ifdef TRACE_SINK_TIMESTAMP_EN
        exp_first = 32'd1;
`else
        exp_first = 32'h00000F01;
`endif
        push(rec);
        wait_valid("post_rst");
        check("post_rst_first", 64'(out_data_o), 64'(exp_first));
        check("post_rst_last", 64'(out_last_o), 64'(0));
        drain();

`ifdef TRACE_SINK_TIMESTAMP_EN
        // Record pushed 40 cycles after reset carries stamp 40
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        repeat (40) step();
        push({lit[2], lit[1], lit[0]});
        wait_valid("ts_start");
        check("ts_stamp", 64'(out_data_o), 64'(40));
        for (int i = 0; i < TW; i++) begin
            step();
            check("ts_word", 64'(out_data_o), 64'(lit[i]));
            check("ts_last", 64'(out_last_o), 64'(i == TW - 1));
        end
        drain();
`endif

        // Random traffic: heavy then light drain rate
        for (int c = 0; c < 3000; c++) begin
            trace_valid_i = ($urandom_range(0, 99) < 45);
            trace_data_i  = {$urandom, $urandom, $urandom};
            out_ready_i   = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 30));
            clear_i       = ($urandom_range(0, 99) < 2);
            step();
        end
        trace_valid_i = 1'b0;
        clear_i       = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
